branch_predict_unit: RTL and testbench

Parametrised next-PC generator for the Fetch stage. It replaces the fixed PC+4 / PC+imm select with an owned PC register, a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and Execute-stage resolution. Each cycle it predicts the next fetch address. When Execute reports a resolved control transfer that disagrees with the prediction, it redirects the PC, raises a flush, and trains the table.

---
 rtl/branch_predict_unit.sv | 124 ++++++++++++
 tb/tb_branch_predict_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Fetch-stage next-PC generator: owned PC register, direct-mapped BTB with
// 2-bit saturating counters, and Execute-stage redirect/training.
module branch_predict_unit #(
  parameter int unsigned    DPW      = 32,
  parameter int unsigned    ENTRIES  = 16,
  parameter logic [DPW-1:0] RESET_PC = '0
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  input  logic           stall_i,
  output logic [DPW-1:0] pcf_o,
  output logic [DPW-1:0] pred_next_o,
  output logic           pred_taken_o,
  input  logic           res_valid_i,
  input  logic [DPW-1:0] res_pc_i,
  input  logic           res_taken_i,
  input  logic [DPW-1:0] res_target_i,
  input  logic [DPW-1:0] res_pred_next_i,
  output logic           mispredict_o,
  output logic [31:0]    mispred_cnt_o
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = DPW - IDXW - 2;
  localparam int unsigned TGTW = DPW - 2;

  logic [DPW-1:0]     pcf_q, pcf_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q [ENTRIES];
  logic [TGTW-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDXW-1:0] f_idx_c, r_idx_c;
  logic [TAGW-1:0] f_tag_c, r_tag_c;
  logic            f_hit_c, r_hit_c;
  logic [DPW-1:0]  actual_c;
  logic            wr_en_c;
  logic [TGTW-1:0] wr_tgt_c;
  logic [1:0]      wr_ctr_c;
  logic            unused_c;

  // Fetch-side lookup on the current PC
  assign f_idx_c      = pcf_q[IDXW+1:2];
  assign f_tag_c      = pcf_q[DPW-1:IDXW+2];
  assign f_hit_c      = valid_q[f_idx_c] && (tag_q[f_idx_c] == f_tag_c);
  assign pred_taken_o = f_hit_c && ctr_q[f_idx_c][1];
  assign pred_next_o  = pred_taken_o ? {tgt_q[f_idx_c], 2'b00} : pcf_q + DPW'(4);

  // Resolve-side lookup and redirect decision
  assign r_idx_c      = res_pc_i[IDXW+1:2];
  assign r_tag_c      = res_pc_i[DPW-1:IDXW+2];
  assign r_hit_c      = valid_q[r_idx_c] && (tag_q[r_idx_c] == r_tag_c);
  assign actual_c     = res_taken_i ? {res_target_i[DPW-1:2], 2'b00} : res_pc_i + DPW'(4);
  assign mispredict_o = res_valid_i && (actual_c != res_pred_next_i);
  assign unused_c     = ^res_target_i[1:0];

  assign pcf_o         = pcf_q;
  assign mispred_cnt_o = cnt_q;

  // Training: allocate on taken miss, nudge counter on hit, skip not-taken miss
  always_comb begin
    wr_en_c  = 1'b0;
    wr_tgt_c = tgt_q[r_idx_c];
    wr_ctr_c = ctr_q[r_idx_c];
    if (res_valid_i) begin
      if (res_taken_i) begin
        wr_en_c  = 1'b1;
        wr_tgt_c = res_target_i[DPW-1:2];
        if (!r_hit_c) begin
          wr_ctr_c = 2'b10;
        end else if (ctr_q[r_idx_c] != 2'b11) begin
          wr_ctr_c = ctr_q[r_idx_c] + 2'd1;
        end
      end else if (r_hit_c) begin
        wr_en_c = 1'b1;
        if (ctr_q[r_idx_c] != 2'b00) begin
          wr_ctr_c = ctr_q[r_idx_c] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    pcf_d = pred_next_o;
    if (mispredict_o) begin
      pcf_d = actual_c;
    end else if (stall_i) begin
      pcf_d = pcf_q;
    end
    cnt_d = cnt_q;
    if (mispredict_o && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pcf_q <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pcf_q <= pcf_d;
      cnt_q <= cnt_d;
    end
  end

  // BTB storage; the write lands at the edge so same-cycle lookups see old data
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (wr_en_c) begin
      valid_q[r_idx_c] <= 1'b1;
      tag_q[r_idx_c]   <= r_tag_c;
      tgt_q[r_idx_c]   <= wr_tgt_c;
      ctr_q[r_idx_c]   <= wr_ctr_c;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed cycles push hand-computed
// expectations, a monitor pops and compares them mid-cycle.
module tb_branch_predict_unit;

  localparam logic [4:0] M_ALL = 5'h1f;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        stall_i;
  logic [31:0] pcf_o, pred_next_o;
  logic        pred_taken_o;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic [31:0] res_target_i;
  logic [31:0] res_pred_next_i;
  logic        mispredict_o;
  logic [31:0] mispred_cnt_o;

  typedef struct {
    logic [31:0] pcf;
    logic        pt;
    logic [31:0] pn;
    logic        mp;
    logic [31:0] cnt;
    logic [4:0]  mask;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_predict_unit #(.DPW(32), .ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .stall_i         (stall_i),
    .pcf_o           (pcf_o),
    .pred_next_o     (pred_next_o),
    .pred_taken_o    (pred_taken_o),
    .res_valid_i     (res_valid_i),
    .res_pc_i        (res_pc_i),
    .res_taken_i     (res_taken_i),
    .res_target_i    (res_target_i),
    .res_pred_next_i (res_pred_next_i),
    .mispredict_o    (mispredict_o),
    .mispred_cnt_o   (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs of each cycle are settled 2 time units after the falling edge
  always begin
    exp_t e;
    @(negedge clk_i);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.mask[0]) cmp(e.name, "pcf",        pcf_o,                 e.pcf);
      if (e.mask[1]) cmp(e.name, "pred_taken", 32'(pred_taken_o),     32'(e.pt));
      if (e.mask[2]) cmp(e.name, "pred_next",  pred_next_o,           e.pn);
      if (e.mask[3]) cmp(e.name, "mispredict", 32'(mispredict_o),     32'(e.mp));
      if (e.mask[4]) cmp(e.name, "cnt",        mispred_cnt_o,         e.cnt);
    end
  end

  // One cycle: drive inputs at the falling edge, enqueue what this cycle should show
  task automatic cyc(input logic rst, input logic st, input logic rv, input logic rt,
                     input logic [31:0] rpc, input logic [31:0] rtgt, input logic [31:0] rpn,
                     input logic [4:0] m, input logic [31:0] e_pcf, input logic e_pt,
                     input logic [31:0] e_pn, input logic e_mp, input logic [31:0] e_cnt,
                     input string nm);
    exp_t e;
    @(negedge clk_i);
    arst_ni         = rst;
    stall_i         = st;
    res_valid_i     = rv;
    res_taken_i     = rt;
    res_pc_i        = rpc;
    res_target_i    = rtgt;
    res_pred_next_i = rpn;
    e.pcf = e_pcf; e.pt = e_pt; e.pn = e_pn; e.mp = e_mp; e.cnt = e_cnt;
    e.mask = m; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    arst_ni = 1'b0; stall_i = 1'b0; res_valid_i = 1'b0; res_taken_i = 1'b0;
    res_pc_i = '0; res_target_i = '0; res_pred_next_i = '0;

    // Reset and sequential fetch
    cyc(0,0,0,0, 0,0,0, M_ALL, 32'h00,0,32'h04,0,0, "reset");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h00,0,32'h04,0,0, "release");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h04,0,32'h08,0,0, "seq4");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h08,0,32'h0c,0,0, "seq8");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h0c,0,32'h10,0,0, "seq12");

    // Loop training: 0x40 taken to 0x20 while predicted fall-through
    cyc(1,0,1,1, 32'h40,32'h20,32'h44, M_ALL, 32'h10,0,32'h14,1,0, "train_mp");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h20,0,32'h24,0,1, "redirect");
    for (int k = 1; k < 8; k++)
      cyc(1,0,0,0, 0,0,0, M_ALL, 32'h20 + 32'(4*k),0,32'h24 + 32'(4*k),0,1, "walk");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h40,1,32'h20,0,1, "loop_hit");

    // Hysteresis: strengthen to 11, one not-taken keeps prediction, second flips it
    cyc(1,0,1,1, 32'h40,32'h20,32'h20, M_ALL, 32'h20,0,32'h24,0,1, "strengthen");
    cyc(1,0,1,0, 32'h40,32'h0,32'h20,  M_ALL, 32'h24,0,32'h28,1,1, "nt1");
    cyc(1,0,1,0, 32'h3c,32'h0,32'h0,   M_ALL, 32'h44,0,32'h48,1,2, "jmp40");
    cyc(1,0,1,0, 32'h40,32'h0,32'h44,  M_ALL, 32'h40,1,32'h20,0,3, "hyst_keep");
    cyc(1,0,1,0, 32'h3c,32'h0,32'h0,   M_ALL, 32'h20,0,32'h24,1,3, "jmp40b");
    cyc(1,0,1,1, 32'h40,32'h20,32'h20, M_ALL, 32'h40,0,32'h44,0,4, "hyst_flip");

    // Aliasing: 0x80 shares index 0 with 0x40
    cyc(1,0,1,0, 32'h7c,32'h0,32'h0,    M_ALL, 32'h44,0,32'h48,1,4, "jmp80");
    cyc(1,0,1,1, 32'h80,32'h100,32'h84, M_ALL, 32'h80,0,32'h84,1,5, "alias_miss");
    cyc(1,0,1,0, 32'h3c,32'h0,32'h0,    M_ALL, 32'h100,0,32'h104,1,6, "jmp40c");
    cyc(1,0,1,0, 32'h7c,32'h0,32'h0,    M_ALL, 32'h40,0,32'h44,1,7, "alias_evict");

    // Stall combined with resolves
    cyc(1,1,1,0, 32'h1fc,32'h0,32'h0,    M_ALL, 32'h80,1,32'h100,1,8, "stall_mp");
    cyc(1,1,1,1, 32'h80,32'h100,32'h100, M_ALL, 32'h200,0,32'h204,0,9, "stall_ok");
    cyc(1,0,1,0, 32'h80,32'h0,32'h84,    M_ALL, 32'h200,0,32'h204,0,9, "held");
    cyc(1,0,1,0, 32'h7c,32'h0,32'h0,     M_ALL, 32'h204,0,32'h208,1,9, "jmp80b");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h80,1,32'h100,0,10, "ctr_updated");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h100,0,32'h104,0,10, "after");

    // Reset mid-run, asserted between edges
    cyc(0,0,0,0, 0,0,0, M_ALL, 32'h00,0,32'h04,0,0, "mid_reset");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h00,0,32'h04,0,0, "release2");
    cyc(1,0,1,0, 32'h7c,32'h0,32'h0, M_ALL, 32'h04,0,32'h08,1,0, "jmp80c");
    cyc(1,0,0,0, 0,0,0, M_ALL, 32'h80,0,32'h84,0,1, "cleared");

    repeat (4) @(negedge clk_i);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
